// File: rtl/decode_stage.sv
// RV32I/RV64I decode stage: decodes on the input side and stores decoded entries in a MAIN + SKID pair.
// Optional build macro DECODE_ILLEGAL_CHECK_EN drives out_illegal for unrecognised encodings.
module decode_stage #(
   parameter int XLEN = 32,
   parameter int PC_W = 32
) (
   input  logic              clk,
   input  logic              reset_n,
   input  logic              flush,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [31:0]       in_instr,
   input  logic [PC_W-1:0]   in_pc,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [PC_W-1:0]   out_pc,
   output logic [6:0]        out_opcode,
   output logic [2:0]        out_funct3,
   output logic [6:0]        out_funct7,
   output logic [4:0]        out_rd,
   output logic [4:0]        out_rs1,
   output logic [4:0]        out_rs2,
   output logic [XLEN-1:0]   out_imm,
   output logic              out_illegal
);

   localparam logic [6:0] OP_R     = 7'b0110011;
   localparam logic [6:0] OP_ILOG  = 7'b0010011;
   localparam logic [6:0] OP_LOAD  = 7'b0000011;
   localparam logic [6:0] OP_JALR  = 7'b1100111;
   localparam logic [6:0] OP_S     = 7'b0100011;
   localparam logic [6:0] OP_B     = 7'b1100011;
   localparam logic [6:0] OP_J     = 7'b1101111;
   localparam logic [6:0] OP_AUIPC = 7'b0010111;
   localparam logic [6:0] OP_LUI   = 7'b0110111;

`ifdef DECODE_ILLEGAL_CHECK_EN
   localparam logic ILL_EN = 1'b1;
`else
   localparam logic ILL_EN = 1'b0;
`endif

   typedef struct packed {
      logic [PC_W-1:0] pc;
      logic [6:0]      opcode;
      logic [2:0]      funct3;
      logic [6:0]      funct7;
      logic [4:0]      rd;
      logic [4:0]      rs1;
      logic [4:0]      rs2;
      logic [XLEN-1:0] imm;
      logic            illegal;
   } entry_t;

   // Every recognised opcode ends in 2'b11, so an opcode miss also covers instr[1:0] != 2'b11.
   function automatic entry_t decode(input logic [31:0] instr, input logic [PC_W-1:0] pc);
      entry_t      e;
      logic [31:0] imm32;
      e       = '0;
      imm32   = 32'd0;
      e.pc    = pc;
      case (instr[6:0])
         OP_R: begin
            e.opcode = instr[6:0];   e.funct3 = instr[14:12]; e.funct7 = instr[31:25];
            e.rd     = instr[11:7];  e.rs1    = instr[19:15]; e.rs2    = instr[24:20];
         end
         OP_ILOG: begin
            e.opcode = instr[6:0];   e.funct3 = instr[14:12]; e.funct7 = instr[31:25];
            e.rd     = instr[11:7];  e.rs1    = instr[19:15];
            imm32    = {{20{instr[31]}}, instr[31:20]};
         end
         OP_LOAD, OP_JALR: begin
            e.opcode = instr[6:0];   e.funct3 = instr[14:12];
            e.rd     = instr[11:7];  e.rs1    = instr[19:15];
            imm32    = {{20{instr[31]}}, instr[31:20]};
         end
         OP_S: begin
            e.opcode = instr[6:0];   e.funct3 = instr[14:12];
            e.rs1    = instr[19:15]; e.rs2    = instr[24:20];
            imm32    = {{20{instr[31]}}, instr[31:25], instr[11:7]};
         end
         OP_B: begin
            e.opcode = instr[6:0];   e.funct3 = instr[14:12];
            e.rs1    = instr[19:15]; e.rs2    = instr[24:20];
            imm32    = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
         end
         OP_J: begin
            e.opcode = instr[6:0];   e.rd     = instr[11:7];
            imm32    = {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};
         end
         OP_AUIPC, OP_LUI: begin
            e.opcode = instr[6:0];   e.rd     = instr[11:7];
            imm32    = {instr[31:12], 12'd0};
         end
         default: begin
            e.illegal = ILL_EN;
         end
      endcase
      e.imm = XLEN'($signed(imm32));
      return e;
   endfunction

   entry_t main_q, main_d, skid_q, skid_d, dec_s;
   logic   main_valid_q, main_valid_d, skid_valid_q, skid_valid_d;
   logic   accept_s;

   // Skid buffer next-state; SKID is only refilled while MAIN is stalled, so it can never be
   // the MAIN source and also capture a new input in the same cycle.
   always_comb begin
      accept_s     = in_valid && !skid_valid_q;
      dec_s        = decode(in_instr, in_pc);
      main_d       = main_q;
      main_valid_d = main_valid_q;
      skid_d       = skid_q;
      skid_valid_d = skid_valid_q;
      if (flush) begin
         main_valid_d = 1'b0;
         skid_valid_d = 1'b0;
      end else if (!main_valid_q || out_ready) begin
         if (skid_valid_q) begin
            main_d       = skid_q;
            main_valid_d = 1'b1;
         end else if (accept_s) begin
            main_d       = dec_s;
            main_valid_d = 1'b1;
         end else begin
            main_valid_d = 1'b0;
         end
         skid_valid_d = 1'b0;
      end else begin
         if (accept_s) begin
            skid_d       = dec_s;
            skid_valid_d = 1'b1;
         end else begin
            skid_valid_d = skid_valid_q;
         end
      end
   end

   // Entry storage with asynchronous clear.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         main_q       <= '0;
         main_valid_q <= 1'b0;
         skid_q       <= '0;
         skid_valid_q <= 1'b0;
      end else begin
         main_q       <= main_d;
         main_valid_q <= main_valid_d;
         skid_q       <= skid_d;
         skid_valid_q <= skid_valid_d;
      end
   end

   assign in_ready    = !skid_valid_q;
   assign out_valid   = main_valid_q;
   assign out_pc      = main_q.pc;
   assign out_opcode  = main_q.opcode;
   assign out_funct3  = main_q.funct3;
   assign out_funct7  = main_q.funct7;
   assign out_rd      = main_q.rd;
   assign out_rs1     = main_q.rs1;
   assign out_rs2     = main_q.rs2;
   assign out_imm     = main_q.imm;
   assign out_illegal = main_q.illegal;

endmodule

// File: tb/tb_decode_stage.sv
// Directed self-checking bench for decode_stage (XLEN=32, PC_W=32).
module tb_decode_stage;

   logic        clk = 1'b0;
   logic        reset_n = 1'b1;
   logic        flush = 1'b0;
   logic        in_valid = 1'b0;
   logic        in_ready;
   logic [31:0] in_instr = 32'd0;
   logic [31:0] in_pc = 32'd0;
   logic        out_valid;
   logic        out_ready = 1'b0;
   logic [31:0] out_pc;
   logic [6:0]  out_opcode;
   logic [2:0]  out_funct3;
   logic [6:0]  out_funct7;
   logic [4:0]  out_rd;
   logic [4:0]  out_rs1;
   logic [4:0]  out_rs2;
   logic [31:0] out_imm;
   logic        out_illegal;

   int n_cmp = 0;
   int n_err = 0;

`ifdef DECODE_ILLEGAL_CHECK_EN
   localparam logic EXP_ILL = 1'b1;
`else
   localparam logic EXP_ILL = 1'b0;
`endif

   decode_stage #(.XLEN(32), .PC_W(32)) dut (
      .clk(clk), .reset_n(reset_n), .flush(flush),
      .in_valid(in_valid), .in_ready(in_ready), .in_instr(in_instr), .in_pc(in_pc),
      .out_valid(out_valid), .out_ready(out_ready), .out_pc(out_pc),
      .out_opcode(out_opcode), .out_funct3(out_funct3), .out_funct7(out_funct7),
      .out_rd(out_rd), .out_rs1(out_rs1), .out_rs2(out_rs2),
      .out_imm(out_imm), .out_illegal(out_illegal)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input logic v, input logic [31:0] instr, input logic [31:0] pc);
      in_valid = v;
      in_instr = instr;
      in_pc    = pc;
   endtask

   task automatic expect_dec(input string tag, input logic [31:0] pc, input logic [6:0] op,
                             input logic [2:0] f3, input logic [6:0] f7, input logic [4:0] rd,
                             input logic [4:0] rs1, input logic [4:0] rs2,
                             input logic [31:0] imm, input logic ill);
      chk({tag, ".valid"},  64'(out_valid),   64'd1);
      chk({tag, ".pc"},     64'(out_pc),      64'(pc));
      chk({tag, ".opcode"}, 64'(out_opcode),  64'(op));
      chk({tag, ".funct3"}, 64'(out_funct3),  64'(f3));
      chk({tag, ".funct7"}, 64'(out_funct7),  64'(f7));
      chk({tag, ".rd"},     64'(out_rd),      64'(rd));
      chk({tag, ".rs1"},    64'(out_rs1),     64'(rs1));
      chk({tag, ".rs2"},    64'(out_rs2),     64'(rs2));
      chk({tag, ".imm"},    64'(out_imm),     64'(imm));
      chk({tag, ".ill"},    64'(out_illegal), 64'(ill));
   endtask

   initial begin
      // Reset state
      #1 reset_n = 1'b0;
      #2;
      chk("rst.valid", 64'(out_valid), 64'd0);
      chk("rst.ready", 64'(in_ready),  64'd1);
      chk("rst.pc",    64'(out_pc),    64'd0);
      chk("rst.imm",   64'(out_imm),   64'd0);
      repeat (2) @(posedge clk);
      #1 reset_n = 1'b1;
      chk("rel.ready", 64'(in_ready), 64'd1);

      // Back-to-back decode stream with out_ready high
      out_ready = 1'b1;
      drive(1'b1, 32'hFFF08293, 32'h100); step();
      expect_dec("addi", 32'h100, 7'h13, 3'd0, 7'h7F, 5'd5, 5'd1, 5'd0, 32'hFFFFFFFF, 1'b0);
      chk("addi.ready", 64'(in_ready), 64'd1);
      drive(1'b1, 32'h123451B7, 32'h104); step();
      expect_dec("lui", 32'h104, 7'h37, 3'd0, 7'h00, 5'd3, 5'd0, 5'd0, 32'h12345000, 1'b0);
      drive(1'b1, 32'hFE000EE3, 32'h108); step();
      expect_dec("beq", 32'h108, 7'h63, 3'd0, 7'h00, 5'd0, 5'd0, 5'd0, 32'hFFFFFFFC, 1'b0);
      drive(1'b1, 32'h402081B3, 32'h10C); step();
      expect_dec("sub", 32'h10C, 7'h33, 3'd0, 7'h20, 5'd3, 5'd1, 5'd2, 32'h0, 1'b0);
      drive(1'b1, 32'h0020A423, 32'h110); step();
      expect_dec("sw", 32'h110, 7'h23, 3'd2, 7'h00, 5'd0, 5'd1, 5'd2, 32'h8, 1'b0);
      drive(1'b1, 32'h0080006F, 32'h114); step();
      expect_dec("jal", 32'h114, 7'h6F, 3'd0, 7'h00, 5'd0, 5'd0, 5'd0, 32'h8, 1'b0);
      drive(1'b1, 32'h0000007F, 32'h118); step();
      expect_dec("illop", 32'h118, 7'h00, 3'd0, 7'h00, 5'd0, 5'd0, 5'd0, 32'h0, EXP_ILL);
      drive(1'b0, 32'h0, 32'h0); step();
      chk("idle.valid", 64'(out_valid), 64'd0);

      // Back-pressure: A, B, C, D with out_ready low for three cycles
      drive(1'b1, 32'hFFF08293, 32'h200); step();
      chk("bp.A.pc", 64'(out_pc), 64'h200);
      out_ready = 1'b0;
      drive(1'b1, 32'h123451B7, 32'h204); step();
      chk("bp.skid.ready", 64'(in_ready), 64'd0);
      chk("bp.A.hold1",    64'(out_pc),   64'h200);
      drive(1'b1, 32'hFE000EE3, 32'h208); step();
      chk("bp.A.hold2",    64'(out_pc),   64'h200);
      chk("bp.A.imm",      64'(out_imm),  64'hFFFFFFFF);
      chk("bp.ready2",     64'(in_ready), 64'd0);
      step();
      chk("bp.A.hold3",    64'(out_pc),   64'h200);
      chk("bp.A.valid",    64'(out_valid), 64'd1);
      out_ready = 1'b1; step();
      chk("bp.B.pc",       64'(out_pc),   64'h204);
      chk("bp.B.imm",      64'(out_imm),  64'h12345000);
      chk("bp.ready.back", 64'(in_ready), 64'd1);
      step();
      chk("bp.C.pc",       64'(out_pc),   64'h208);
      drive(1'b1, 32'h402081B3, 32'h20C); step();
      chk("bp.D.pc",       64'(out_pc),   64'h20C);
      chk("bp.D.f7",       64'(out_funct7), 64'h20);
      drive(1'b0, 32'h0, 32'h0); step();
      chk("bp.empty",      64'(out_valid), 64'd0);

      // Flush with both entries full and an instruction offered
      drive(1'b1, 32'hFFF08293, 32'h300); step();
      out_ready = 1'b0;
      drive(1'b1, 32'h123451B7, 32'h304); step();
      chk("fl.full.ready", 64'(in_ready), 64'd0);
      flush = 1'b1;
      drive(1'b1, 32'h0020A423, 32'h3F0); step();
      flush = 1'b0;
      chk("fl.valid", 64'(out_valid), 64'd0);
      chk("fl.ready", 64'(in_ready),  64'd1);
      drive(1'b0, 32'h0, 32'h0);
      out_ready = 1'b1; step();
      chk("fl.noE", 64'(out_valid), 64'd0);

      // Flush discards a same-cycle accepted input
      drive(1'b1, 32'hFFF08293, 32'h400); step();
      out_ready = 1'b0;
      flush = 1'b1;
      drive(1'b1, 32'h0080006F, 32'h404); step();
      flush = 1'b0;
      drive(1'b0, 32'h0, 32'h0);
      chk("fl2.valid", 64'(out_valid), 64'd0);
      out_ready = 1'b1; step();
      chk("fl2.gone", 64'(out_valid), 64'd0);

      // Asynchronous reset while stalled with both entries full
      drive(1'b1, 32'hFFF08293, 32'h500); step();
      out_ready = 1'b0;
      drive(1'b1, 32'h123451B7, 32'h504); step();
      drive(1'b0, 32'h0, 32'h0);
      #3 reset_n = 1'b0;
      #1;
      chk("ar.valid", 64'(out_valid), 64'd0);
      chk("ar.pc",    64'(out_pc),    64'd0);
      chk("ar.imm",   64'(out_imm),   64'd0);
      chk("ar.rd",    64'(out_rd),    64'd0);
      chk("ar.ready", 64'(in_ready),  64'd1);
      #1 reset_n = 1'b1;
      out_ready = 1'b1;
      drive(1'b1, 32'h0020A423, 32'h600); step();
      expect_dec("ar.first", 32'h600, 7'h23, 3'd2, 7'h00, 5'd0, 5'd1, 5'd2, 32'h8, 1'b0);
      drive(1'b0, 32'h0, 32'h0); step();
      chk("ar.drained", 64'(out_valid), 64'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
